// File: rtl/riscv_pkg.sv
// Shared front-end definitions: widths, reset PC, NOP encoding, major opcodes and the
// fetch-buffer entry layout.
package riscv_pkg;

  localparam int unsigned      XLEN      = 32;
  localparam logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000;
  localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, used for the PC-tag queue and the instruction buffer.
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = fetch_entry_t
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  T                             data_i,
  input  logic                         pop_i,
  output T                             head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(push_i && full_o && !pop_i && !flush_i))
    else $error("fetch_fifo: push into full FIFO");
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, credit-limited imem requests, in-order response
// tagging and a registered instruction buffer feeding decode; redirects squash in-flight words.
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  logic            started_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   inflight, buf_count;
  logic [CW:0]     credits_used;
  logic [XLEN-1:0] tag_pc;
  entry_t          buf_in, buf_head;
  logic            tag_empty, tag_full, buf_empty, buf_full;
  logic            req_accept, rsp_keep, buf_pop;

  // Every in-flight or buffered word holds one credit, so a kept response always has room.
  assign credits_used   = {1'b0, inflight} + {1'b0, buf_count};
  assign imem_req_valid = started_q && (credits_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_accept     = imem_req_valid && imem_req_ready;

  assign rsp_keep = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
  assign buf_in   = '{pc: tag_pc, instr: imem_rsp_data};

  assign if_valid = !buf_empty;
  assign buf_pop  = if_valid && if_ready;
  assign if_pc    = if_valid ? buf_head.pc    : pc_q;
  assign if_instr = if_valid ? buf_head.instr : riscv_pkg::NOP_INSTR;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)  pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    else if (req_accept) pc_d = pc_q + XLEN'(4);
  end

  // A redirect writes off everything still owed by imem, including this cycle's accept.
  always_comb begin
    drop_d = drop_q;
    if (redirect_valid)
      drop_d = inflight + CW'(req_accept) - CW'(imem_rsp_valid);
    else if (imem_rsp_valid && (drop_q != '0))
      drop_d = drop_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q <= 1'b0;
      pc_q      <= RESET_PC;
      drop_q    <= '0;
    end else begin
      started_q <= 1'b1;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
    end
  end

  // Tags are never flushed: each outstanding response, kept or dropped, retires its tag.
  fetch_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_tag_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (1'b0),
    .push_i  (req_accept),
    .data_i  (pc_q),
    .pop_i   (imem_rsp_valid),
    .head_o  (tag_pc),
    .count_o (inflight),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  fetch_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_ibuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (rsp_keep),
    .data_i  (buf_in),
    .pop_i   (buf_pop),
    .head_o  (buf_head),
    .count_o (buf_count),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (!rst_n) !(imem_rsp_valid && tag_empty))
    else $error("instr_fetch_unit: response with nothing in flight");
  assert property (@(posedge clk) disable iff (!rst_n) !(req_accept && tag_full))
    else $error("instr_fetch_unit: request beyond credit limit");
  assert property (@(posedge clk) disable iff (!rst_n) !(rsp_keep && buf_full && !buf_pop))
    else $error("instr_fetch_unit: kept response into full buffer");
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order, variable-latency imem model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int checks = 0;
  int failures = 0;

  bit rdy_rand = 1'b0;
  int lat_min = 1;
  int lat_max = 1;
  int cyc = 0;
  int last_due = 0;

  typedef struct {logic [31:0] addr; int due;} pend_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} pop_t;
  pend_t       pend[$];
  logic [31:0] reqs[$];
  pop_t        popped[$];

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2] ^ 30'h2345_6789, 2'b11};
  endfunction

  // imem model: drives ready/response at each falling edge, one response per accept, in order
  always @(negedge clk) begin
    int lat;
    int due;
    cyc++;
    imem_rsp_valid = 1'b0;
    if (!rst_n) begin
      pend.delete();
      last_due = 0;
      imem_req_ready = 1'b0;
    end else begin
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end
      imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (imem_req_valid === 1'b1 && imem_req_ready) begin
        lat = int'($urandom_range(lat_min, lat_max));
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend.push_back('{imem_req_addr, due});
        reqs.push_back(imem_req_addr);
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst_n && if_valid === 1'b1 && if_ready) popped.push_back('{if_pc, if_instr});
  end

  task automatic do_reset(input logic dec_ready);
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    if_ready = dec_ready;
    repeat (2) @(negedge clk);
    reqs.delete();
    popped.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rdy_rand = 1'b0; lat_min = 1; lat_max = 1;
    @(negedge clk);
    #1 rst_n = 1'b0; if_ready = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_if_valid got=%b exp=0", if_valid); end
    checks++; if (if_instr !== NOP) begin failures++; $display("FAIL reset_if_instr got=%h exp=%h", if_instr, NOP); end
    checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL reset_if_pc got=%h exp=00000000", if_pc); end
    repeat (2) @(negedge clk);
    reqs.delete(); popped.delete();
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL release_req_valid got=%b exp=0", imem_req_valid); end
    @(negedge clk); #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      failures++; $display("FAIL first_req got valid=%b addr=%h exp valid=1 addr=00000000", imem_req_valid, imem_req_addr); end
    @(negedge clk); #1;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL latency_early got if_valid=%b exp=0", if_valid); end
    @(negedge clk); #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== mem_word(32'h0)) begin
      failures++; $display("FAIL first_word got v=%b pc=%h instr=%h exp v=1 pc=00000000 instr=%h", if_valid, if_pc, if_instr, mem_word(32'h0)); end
  endtask

  task automatic test_stream();
    repeat (20) @(negedge clk);
    #3;
    checks++; if (reqs.size() < 8) begin failures++; $display("FAIL stream_req_count got=%0d exp>=8", reqs.size()); end
    else for (int i = 0; i < 8; i++) begin
      checks++; if (reqs[i] !== 32'(4 * i)) begin failures++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, reqs[i], 32'(4 * i)); end
    end
    checks++; if (popped.size() < 6) begin failures++; $display("FAIL stream_pop_count got=%0d exp>=6", popped.size()); end
    else for (int i = 0; i < 6; i++) begin
      checks++; if (popped[i].pc !== 32'(4 * i) || popped[i].instr !== mem_word(32'(4 * i))) begin
        failures++; $display("FAIL stream_pop[%0d] got pc=%h instr=%h exp pc=%h instr=%h", i, popped[i].pc, popped[i].instr, 32'(4 * i), mem_word(32'(4 * i))); end
    end
  endtask

  task automatic test_stall();
    int n;
    rdy_rand = 1'b0; lat_min = 1; lat_max = 1;
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #3;
      if (i >= 3) begin
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== mem_word(32'h0)) begin
          failures++; $display("FAIL stall_hold[%0d] got v=%b pc=%h instr=%h exp v=1 pc=00000000 instr=%h", i, if_valid, if_pc, if_instr, mem_word(32'h0)); end
      end
    end
    checks++; if (reqs.size() != 2) begin failures++; $display("FAIL stall_req_count got=%0d exp=2", reqs.size()); end
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_req_valid got=%b exp=0", imem_req_valid); end
    @(negedge clk); if_ready = 1'b1;
    n = 0;
    while (popped.size() < 4 && n < 30) begin @(negedge clk); #3; n++; end
    checks++; if (popped.size() < 4) begin failures++; $display("FAIL stall_resume_timeout got=%0d pops exp>=4", popped.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (popped[i].pc !== 32'(4 * i) || popped[i].instr !== mem_word(32'(4 * i))) begin
        failures++; $display("FAIL stall_resume[%0d] got pc=%h instr=%h exp pc=%h", i, popped[i].pc, popped[i].instr, 32'(4 * i)); end
    end
  endtask

  task automatic test_redirect_inflight();
    int n;
    rdy_rand = 1'b0; lat_min = 3; lat_max = 3;
    do_reset(1'b1);
    n = 0;
    while (reqs.size() < 2 && n < 20) begin @(negedge clk); #3; n++; end
    checks++; if (reqs.size() != 2) begin failures++; $display("FAIL redir_setup got=%0d reqs exp=2", reqs.size()); end
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk); redirect_valid = 1'b0;
    n = 0;
    while (popped.size() < 2 && n < 40) begin @(negedge clk); #3; n++; end
    checks++; if (popped.size() < 2) begin failures++; $display("FAIL redir_timeout got=%0d pops exp>=2", popped.size()); end
    else begin
      checks++; if (popped[0].pc !== 32'h100 || popped[0].instr !== mem_word(32'h100)) begin
        failures++; $display("FAIL redir_first got pc=%h instr=%h exp pc=00000100 instr=%h", popped[0].pc, popped[0].instr, mem_word(32'h100)); end
      checks++; if (popped[1].pc !== 32'h104 || popped[1].instr !== mem_word(32'h104)) begin
        failures++; $display("FAIL redir_second got pc=%h instr=%h exp pc=00000104", popped[1].pc, popped[1].instr); end
    end
    checks++; if (reqs.size() < 3 || reqs[2] !== 32'h100) begin
      failures++; $display("FAIL redir_req got size=%0d exp third addr=00000100", reqs.size()); end
  endtask

  task automatic test_redirect_coincident();
    rdy_rand = 1'b0; lat_min = 1; lat_max = 1;
    do_reset(1'b1);
    @(negedge clk);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    #3;
    checks++; if (imem_rsp_valid !== 1'b1 || imem_req_valid !== 1'b1) begin
      failures++; $display("FAIL coinc_setup got rsp=%b req=%b exp 1/1", imem_rsp_valid, imem_req_valid); end
    @(negedge clk); redirect_valid = 1'b0; #1;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL coinc_drop1 got if_valid=%b pc=%h exp 0", if_valid, if_pc); end
    @(negedge clk); #1;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL coinc_drop2 got if_valid=%b pc=%h exp 0", if_valid, if_pc); end
    @(negedge clk); #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== mem_word(32'h200)) begin
      failures++; $display("FAIL coinc_target got v=%b pc=%h instr=%h exp v=1 pc=00000200", if_valid, if_pc, if_instr); end
    repeat (10) @(negedge clk);
    #3;
    checks++; if (popped.size() < 4) begin failures++; $display("FAIL coinc_count got=%0d exp>=4", popped.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (popped[i].pc !== 32'h200 + 32'(4 * i)) begin
        failures++; $display("FAIL coinc_seq[%0d] got pc=%h exp=%h", i, popped[i].pc, 32'h200 + 32'(4 * i)); end
    end
  endtask

  task automatic test_random();
    rdy_rand = 1'b1; lat_min = 1; lat_max = 4;
    do_reset(1'b0);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk); if_ready = 1'b0; #3;
    rdy_rand = 1'b0;
    checks++; if (popped.size() < 40) begin failures++; $display("FAIL rand_count got=%0d exp>=40", popped.size()); end
    for (int i = 0; i < popped.size(); i++) begin
      checks++; if (popped[i].pc !== 32'(4 * i) || popped[i].instr !== mem_word(32'(4 * i))) begin
        failures++; $display("FAIL rand_sb[%0d] got pc=%h instr=%h exp pc=%h instr=%h", i, popped[i].pc, popped[i].instr, 32'(4 * i), mem_word(32'(4 * i))); end
    end
  endtask

  task automatic test_wrap_and_reset();
    int np;
    int nr;
    int n;
    rdy_rand = 1'b0; lat_min = 1; lat_max = 1;
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    #3;
    np = popped.size(); nr = reqs.size();
    @(negedge clk); redirect_valid = 1'b0; if_ready = 1'b1;
    n = 0;
    while (popped.size() < np + 2 && n < 30) begin @(negedge clk); #3; n++; end
    checks++; if (reqs.size() < nr + 2 || reqs[nr] !== 32'hFFFF_FFFC || reqs[nr+1] !== 32'h0) begin
      failures++; $display("FAIL wrap_reqs got size=%0d exp addrs fffffffc,00000000 from index %0d", reqs.size(), nr); end
    checks++; if (popped.size() < np + 2) begin failures++; $display("FAIL wrap_timeout got=%0d exp>=%0d", popped.size(), np + 2); end
    else begin
      checks++; if (popped[np].pc !== 32'hFFFF_FFFC || popped[np].instr !== mem_word(32'hFFFF_FFFC)) begin
        failures++; $display("FAIL wrap_top got pc=%h instr=%h exp pc=fffffffc", popped[np].pc, popped[np].instr); end
      checks++; if (popped[np+1].pc !== 32'h0 || popped[np+1].instr !== mem_word(32'h0)) begin
        failures++; $display("FAIL wrap_zero got pc=%h instr=%h exp pc=00000000", popped[np+1].pc, popped[np+1].instr); end
    end
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL midrst_req_valid got=%b exp=0", imem_req_valid); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL midrst_if_valid got=%b exp=0", if_valid); end
    checks++; if (if_instr !== NOP) begin failures++; $display("FAIL midrst_if_instr got=%h exp=%h", if_instr, NOP); end
    checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL midrst_if_pc got=%h exp=00000000", if_pc); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_coincident();
    test_random();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
